// File: rtl/eucdist_pkg.sv
// eucdist_pkg: shared definitions for the Euclidean-distance sequencer.
//   eucseq_state_t : sequencer FSM state encoding
//   DIST_W         : width of the distance result and element data
//   DIST_ERR       : sentinel result reported when the datapath times out
package eucdist_pkg;

    localparam int DIST_W = 16;
    localparam logic [DIST_W-1:0] DIST_ERR = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_WAIT,
        S_HOLD
    } eucseq_state_t;

endpackage

// File: rtl/eucdist_seq_valid_delay.sv
// valid_delay: resettable 1-bit shift register of DEPTH stages.
// Used to delay the RAM read enable so the datapath strobe lines up with
// read data returning from a RAM of DEPTH cycles latency.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; clears every stage
//   din   : bit entering the pipeline
//   dout  : bit leaving the pipeline, DEPTH cycles later
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/eucdist_seq.sv
// eucdist_seq: sequencer for the Euclidean-distance datapath.
// On start it flushes the datapath accumulator, streams N_ELEM element pairs
// from two synchronous-read RAMs into the datapath, waits for the datapath's
// op_done and presents the captured result on a valid/ready port.
//
// Optional feature macro: EUCDIST_SEQ_TIMEOUT_EN
//   defined   : WAIT is bounded by TIMEOUT_CYC cycles; on expiry the result
//               is DIST_ERR and err is set.
//   undefined : WAIT is unbounded and err is constant 0.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : command request, honoured only in IDLE
//   busy                : high in every state except IDLE
//   rd_en, rd_addr      : shared read enable / address for RAMs A and B
//   ram_a, ram_b        : RAM read data
//   dp_enable           : datapath enable; low clears its accumulator
//   dp_ctrl             : accumulate strobe, aligned with dp_a/dp_b
//   dp_a, dp_b          : element pair to the datapath
//   dp_op_done, dp_result : datapath result handshake
//   res_valid, res_ready, res_data : result port
//   err                 : timeout flag, meaningful while res_valid is high
//
// State | meaning
// IDLE   | waiting for start
// CLEAR  | one cycle with dp_enable low to flush the accumulator
// STREAM | issuing RAM reads, one address per cycle
// DRAIN  | RAM_LAT cycles letting the last reads reach the datapath
// WAIT   | waiting for dp_op_done (or timeout)
// HOLD   | result presented until res_ready
module eucdist_seq
    import eucdist_pkg::*;
#(
    parameter int N_ELEM  = 1024,
    parameter int ADDR_W  = $clog2(N_ELEM),
    parameter int RAM_LAT = 2
`ifdef EUCDIST_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DIST_W-1:0] ram_a,
    input  logic [DIST_W-1:0] ram_b,
    output logic              dp_enable,
    output logic              dp_ctrl,
    output logic [DIST_W-1:0] dp_a,
    output logic [DIST_W-1:0] dp_b,
    input  logic              dp_op_done,
    input  logic [DIST_W-1:0] dp_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DIST_W-1:0] res_data,
    output logic              err
);

    eucseq_state_t     state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        drain_cnt;
    logic              last_addr;
    logic              drain_tc;
    logic              wait_expired;

    assign last_addr = (addr_cnt == ADDR_W'(N_ELEM - 1));
    assign drain_tc  = (drain_cnt == 2'd0);

`ifdef EUCDIST_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;

    assign wait_expired = (state == S_WAIT) && (wait_cnt == '0);

    // Down-counter reloaded outside WAIT; reaching zero in the last allowed
    // WAIT cycle means exactly TIMEOUT_CYC cycles are spent waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != S_WAIT) begin
                wait_cnt <= WAIT_W'(TIMEOUT_CYC - 1);
            end else if (!wait_expired) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (state == S_WAIT) begin
                if (dp_op_done) begin
                    err_q <= 1'b0;
                end else if (wait_expired) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign err = err_q;
`else
    assign wait_expired = 1'b0;
    assign err          = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_STREAM;
            S_STREAM: if (last_addr) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_tc) state_nxt = S_WAIT;
            S_WAIT:   if (dp_op_done || wait_expired) state_nxt = S_HOLD;
            S_HOLD:   if (res_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_cnt  <= '0;
            drain_cnt <= '0;
            res_data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_CLEAR: addr_cnt <= '0;
                S_STREAM: begin
                    addr_cnt  <= addr_cnt + ADDR_W'(1);
                    drain_cnt <= 2'(RAM_LAT - 1);
                end
                S_DRAIN: if (!drain_tc) drain_cnt <= drain_cnt - 2'd1;
                S_WAIT: begin
                    if (dp_op_done) begin
                        res_data <= dp_result;
`ifdef EUCDIST_SEQ_TIMEOUT_EN
                    end else if (wait_expired) begin
                        res_data <= DIST_ERR;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // rd_en travels alongside the read so dp_ctrl arrives with the data.
    valid_delay #(
        .DEPTH(RAM_LAT)
    ) u_valid_delay (
        .clk  (clk),
        .reset(reset),
        .din  (rd_en),
        .dout (dp_ctrl)
    );

    assign busy      = (state != S_IDLE);
    assign rd_en     = (state == S_STREAM);
    assign rd_addr   = addr_cnt;
    assign dp_enable = (state == S_STREAM) || (state == S_DRAIN) || (state == S_WAIT);
    assign dp_a      = ram_a;
    assign dp_b      = ram_b;
    assign res_valid = (state == S_HOLD);

endmodule

// File: tb/tb_eucdist_seq.sv
// tb_eucdist_seq: self-checking bench for eucdist_seq with N_ELEM=4, RAM_LAT=2.
// Contains synchronous-read RAM models, a behavioural distance datapath, and a
// reference computation of the expected distance from the RAM contents.
// Build with EUCDIST_SEQ_TIMEOUT_EN to also exercise the timeout path.
module tb_eucdist_seq;

    localparam int N_ELEM      = 4;
    localparam int ADDR_W      = 2;
    localparam int RAM_LAT     = 2;
    localparam int TIMEOUT_CYC = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       ram_a, ram_b;
    logic              dp_enable, dp_ctrl;
    logic [15:0]       dp_a, dp_b;
    logic              dp_op_done;
    logic [15:0]       dp_result;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [15:0]       res_data;
    logic              err;

    always #5 clk = ~clk;

    eucdist_seq #(
        .N_ELEM (N_ELEM),
        .ADDR_W (ADDR_W),
        .RAM_LAT(RAM_LAT)
`ifdef EUCDIST_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .ram_a     (ram_a),
        .ram_b     (ram_b),
        .dp_enable (dp_enable),
        .dp_ctrl   (dp_ctrl),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_op_done(dp_op_done),
        .dp_result (dp_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // RAM models: synchronous read, RAM_LAT cycles from rd_en to data.
    logic [15:0] mem_a [N_ELEM];
    logic [15:0] mem_b [N_ELEM];
    logic [15:0] pipe_a [RAM_LAT] = '{default: 16'h0};
    logic [15:0] pipe_b [RAM_LAT] = '{default: 16'h0};

    always @(posedge clk) begin
        pipe_a[0] <= rd_en ? mem_a[rd_addr] : 16'h0;
        pipe_b[0] <= rd_en ? mem_b[rd_addr] : 16'h0;
        for (int i = 1; i < RAM_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign ram_a = pipe_a[RAM_LAT-1];
    assign ram_b = pipe_b[RAM_LAT-1];

    // Behavioural datapath: accumulates squared differences on dp_ctrl and
    // reports sqrt five cycles after the N_ELEM-th strobe.
    longint      acc = 0;
    int          npulse = 0;
    int          cd = -1;
    bit          model_never = 1'b0;
    logic        model_done = 1'b0;
    logic [15:0] model_res = 16'h0;
    logic        stray_done = 1'b0;

    always @(posedge clk) begin
        if (reset || !dp_enable) begin
            acc = 0;
            npulse = 0;
            cd = -1;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (dp_ctrl) begin
                longint d;
                d = longint'(dp_a) - longint'(dp_b);
                acc += d * d;
                npulse++;
                if (npulse == N_ELEM) cd = 5;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    cd = -1;
                    if (!model_never) begin
                        model_done <= 1'b1;
                        model_res  <= 16'(isqrt(acc));
                    end
                end
            end
        end
    end
    assign dp_op_done = model_done | stray_done;
    assign dp_result  = stray_done ? 16'h1234 : model_res;

    // Cycle-relative monitor of dp_ctrl and model done.
    int cyc = 0;
    int t_start = 0;
    int pulses = 0;
    int first_rel = -1;
    int last_rel = -1;
    int done_rel = -100;
    bit nonconsec = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int rel;
        rel = cyc - t_start;
        if (dp_ctrl) begin
            if (pulses == 0) first_rel = rel;
            else if (rel != last_rel + 1) nonconsec = 1'b1;
            last_rel = rel;
            pulses++;
        end
        if (model_done) done_rel = rel;
    end

    task automatic run_cmd(input string name, input int hold_cyc, input bit poke_start,
                           input bit poke_stray, input bit exp_to);
        longint sum = 0;
        longint exp_res;
        longint exp_err;
        int     rel;
        bit     got_valid = 1'b0;
        bit     stable = 1'b1;
        logic [15:0] held;
        for (int i = 0; i < N_ELEM; i++) begin
            longint d;
            d = longint'(mem_a[i]) - longint'(mem_b[i]);
            sum += d * d;
        end
        exp_res = exp_to ? 64'hFFFF : isqrt(sum);
        exp_err = exp_to ? 1 : 0;

        @(negedge clk);
        start = 1'b1;
        t_start = cyc;
        pulses = 0;
        nonconsec = 1'b0;
        first_rel = -1;
        last_rel = -1;
        done_rel = -100;
        @(negedge clk);
        start = 1'b0;
        check_val({name, ":clear_busy"}, busy, 1);
        check_val({name, ":clear_dp_enable"}, dp_enable, 0);
        check_val({name, ":clear_rd_en"}, rd_en, 0);

        for (rel = 2; rel < 200; rel++) begin
            @(negedge clk);
            start = poke_start && (rel == 2);
            stray_done = poke_stray && (rel == 3);
            if (rel >= 2 && rel < 2 + N_ELEM) begin
                check_val({name, ":stream_rd_en"}, rd_en, 1);
                check_val({name, ":stream_addr"}, rd_addr, rel - 2);
            end
            if (res_valid) begin
                got_valid = 1'b1;
                break;
            end
        end
        start = 1'b0;
        stray_done = 1'b0;
        check_val({name, ":result_arrived"}, got_valid, 1);
        if (!got_valid) return;

        if (exp_to) check_val({name, ":timeout_hold_cycle"}, rel, 2 + N_ELEM + RAM_LAT + TIMEOUT_CYC);
        else        check_val({name, ":valid_after_done"}, rel, done_rel + 1);
        check_val({name, ":ctrl_pulses"}, pulses, N_ELEM);
        check_val({name, ":ctrl_first"}, first_rel, 2 + RAM_LAT);
        check_val({name, ":ctrl_last"}, last_rel, 1 + N_ELEM + RAM_LAT);
        check_val({name, ":ctrl_consecutive"}, nonconsec, 0);
        check_val({name, ":res_data"}, res_data, exp_res);
        check_val({name, ":err"}, err, exp_err);
        check_val({name, ":hold_dp_enable"}, dp_enable, 0);

        held = res_data;
        for (int k = 0; k < hold_cyc; k++) begin
            start = poke_start && (k == 0);
            @(negedge clk);
            if (!res_valid || res_data !== held) stable = 1'b0;
        end
        check_val({name, ":hold_stable"}, stable, 1);

        res_ready = 1'b1;
        start = poke_start;
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        check_val({name, ":post_hs_valid"}, res_valid, 0);
        check_val({name, ":post_hs_busy"}, busy, 0);
        @(negedge clk);
        check_val({name, ":start_ignored_busy"}, busy, 0);
        check_val({name, ":start_ignored_pulses"}, pulses, N_ELEM);
    endtask

    task automatic check_reset_values(input string name);
        check_val({name, ":busy"}, busy, 0);
        check_val({name, ":rd_en"}, rd_en, 0);
        check_val({name, ":rd_addr"}, rd_addr, 0);
        check_val({name, ":dp_enable"}, dp_enable, 0);
        check_val({name, ":dp_ctrl"}, dp_ctrl, 0);
        check_val({name, ":res_valid"}, res_valid, 0);
        check_val({name, ":res_data"}, res_data, 0);
        check_val({name, ":err"}, err, 0);
    endtask

    initial begin
        for (int i = 0; i < N_ELEM; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Basic command: distance of (3,0) and (0,4) is 5.
        mem_a[0] = 16'd3; mem_b[1] = 16'd4;
        run_cmd("basic", 0, 1'b0, 1'b0, 1'b0);

        // Backpressure for 10 cycles.
        run_cmd("backpressure", 10, 1'b0, 1'b0, 1'b0);

        // Starts during STREAM, HOLD and the handshake cycle are dropped.
        run_cmd("ignored_start", 3, 1'b1, 1'b0, 1'b0);

        // Stray done during STREAM must not be captured.
        run_cmd("stray_done", 2, 1'b0, 1'b1, 1'b0);

        // Reset mid-STREAM, then a fresh command with identical vectors.
        for (int i = 0; i < N_ELEM; i++) begin
            mem_a[i] = 16'(i * 100 + 7);
            mem_b[i] = 16'(i * 3);
        end
        @(negedge clk);
        start = 1'b1;
        t_start = cyc;
        pulses = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midreset:pre_rd_en", rd_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("midreset");
        pulses = 0;
        repeat (4) @(negedge clk);
        check_val("midreset:no_stale_ctrl", pulses, 0);
        check_val("midreset:stays_idle", busy, 0);
        for (int i = 0; i < N_ELEM; i++) begin
            mem_a[i] = 16'd1;
            mem_b[i] = 16'd1;
        end
        run_cmd("after_reset", 1, 1'b0, 1'b0, 1'b0);

        // Randomised commands.
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < N_ELEM; i++) begin
                mem_a[i] = 16'($urandom_range(0, 1000));
                mem_b[i] = 16'($urandom_range(0, 1000));
            end
            run_cmd($sformatf("rand%0d", n), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef EUCDIST_SEQ_TIMEOUT_EN
        model_never = 1'b1;
        run_cmd("timeout", 2, 1'b0, 1'b0, 1'b1);
        model_never = 1'b0;
        run_cmd("post_timeout", 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
